etapa_fetch: RTL and testbench

//  Instruction-fetch stage with the IF/ID pipeline register for the filter processor pipeline.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/pc_contador.sv | 46 ++++
 rtl/etapa_fetch.sv | 123 ++++++++++++
 tb/tb_etapa_fetch.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// ============================================================================
//  fetch_pkg : shared constants and the IF/ID payload type for the fetch stage
//  Revision  : 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

    localparam int unsigned PC_W      = 32;
    localparam int unsigned INSTR_W   = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [PC_W-1:0]    RESET_PC  = 32'h0000_0000;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
        logic               valid;
    } ifid_t;

endpackage

`default_nettype wire

// File: rtl/pc_contador.sv
// ============================================================================
//  pc_contador : program counter with redirect load, hold and increment
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module pc_contador
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC_VAL = fetch_pkg::RESET_PC,
    parameter logic [PC_W-1:0] PC_INC       = 32'd4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic [PC_W-1:0] load_val_i,
    input  logic            inc_i,
    output logic [PC_W-1:0] pc_o
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    // Load beats increment; neither asserted means hold. The add wraps naturally.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            pc_d = pc_q + PC_INC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC_VAL;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

`default_nettype wire

// File: rtl/etapa_fetch.sv
// ============================================================================
//  etapa_fetch : instruction fetch stage and IF/ID register; optional perf
//                counters enabled by defining FETCH_PERF_CNT_EN
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module etapa_fetch
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0]    RESET_PC_VAL  = fetch_pkg::RESET_PC,
    parameter logic [PC_W-1:0]    PC_INC        = 32'd4,
    parameter logic [INSTR_W-1:0] NOP_INSTR_VAL = fetch_pkg::NOP_INSTR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_i,
    input  logic               br_taken_i,
    input  logic [PC_W-1:0]    br_target_i,
    output logic [PC_W-1:0]    imem_addr_o,
    output logic               imem_en_o,
    input  logic [INSTR_W-1:0] imem_data_i,
    input  logic               imem_rdy_i,
    output logic [INSTR_W-1:0] ifid_instr_o,
    output logic [PC_W-1:0]    ifid_pc_o,
    output logic               ifid_valid_o,
    output logic [31:0]        perf_stall_o,
    output logic [31:0]        perf_flush_o
);

    logic [PC_W-1:0] pc;
    logic            fetch_now;
    ifid_t           ifid_q;
    ifid_t           ifid_d;

    assign fetch_now = ~br_taken_i & ~stall_i & imem_rdy_i;

    pc_contador #(
        .RESET_PC_VAL (RESET_PC_VAL),
        .PC_INC       (PC_INC)
    ) u_pc (
        .clk        (clk),
        .rst        (rst),
        .load_i     (br_taken_i),
        .load_val_i (br_target_i),
        .inc_i      (fetch_now),
        .pc_o       (pc)
    );

    assign imem_addr_o = pc;
    assign imem_en_o   = ~stall_i & ~rst;

    // Redirect flushes even a stalled IF/ID; a not-ready memory injects a bubble
    // but leaves ifid_pc alone.
    always_comb begin
        ifid_d = ifid_q;
        if (br_taken_i) begin
            ifid_d.instr = NOP_INSTR_VAL;
            ifid_d.pc    = '0;
            ifid_d.valid = 1'b0;
        end else if (stall_i) begin
            ifid_d = ifid_q;
        end else if (!imem_rdy_i) begin
            ifid_d.instr = NOP_INSTR_VAL;
            ifid_d.valid = 1'b0;
        end else begin
            ifid_d.instr = imem_data_i;
            ifid_d.pc    = pc;
            ifid_d.valid = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_q.instr <= NOP_INSTR_VAL;
            ifid_q.pc    <= '0;
            ifid_q.valid <= 1'b0;
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign ifid_instr_o = ifid_q.instr;
    assign ifid_pc_o    = ifid_q.pc;
    assign ifid_valid_o = ifid_q.valid;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_stall_d;
    logic [31:0] perf_flush_q;
    logic [31:0] perf_flush_d;

    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if (stall_i && (perf_stall_q != 32'hFFFF_FFFF)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
        if (br_taken_i && (perf_flush_q != 32'hFFFF_FFFF)) begin
            perf_flush_d = perf_flush_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_stall_o = perf_stall_q;
    assign perf_flush_o = perf_flush_q;
`else
    assign perf_stall_o = 32'h0;
    assign perf_flush_o = 32'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_etapa_fetch.sv
// ============================================================================
//  tb_etapa_fetch : directed + random checks of etapa_fetch against a model
//  Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_etapa_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        br_taken_i;
    logic [31:0] br_target_i;
    logic [31:0] imem_addr_o;
    logic        imem_en_o;
    logic [31:0] imem_data_i;
    logic        imem_rdy_i;
    logic [31:0] ifid_instr_o;
    logic [31:0] ifid_pc_o;
    logic        ifid_valid_o;
    logic [31:0] perf_stall_o;
    logic [31:0] perf_flush_o;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_ifid_pc;
    logic        m_valid;
    logic        m_pc_known;
    logic [31:0] m_stalls;
    logic [31:0] m_flushes;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5B;
    endfunction

    assign imem_data_i = mem_word(imem_addr_o);

    etapa_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .br_taken_i   (br_taken_i),
        .br_target_i  (br_target_i),
        .imem_addr_o  (imem_addr_o),
        .imem_en_o    (imem_en_o),
        .imem_data_i  (imem_data_i),
        .imem_rdy_i   (imem_rdy_i),
        .ifid_instr_o (ifid_instr_o),
        .ifid_pc_o    (ifid_pc_o),
        .ifid_valid_o (ifid_valid_o),
        .perf_stall_o (perf_stall_o),
        .perf_flush_o (perf_flush_o)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // One clock: drive inputs, check combinational outputs, then the registered result.
    task automatic step(input logic r, input logic s, input logic b,
                        input logic [31:0] t, input logic rdy);
        @(negedge clk);
        rst = r; stall_i = s; br_taken_i = b; br_target_i = t; imem_rdy_i = rdy;
        #1;
        check_eq("imem_addr", imem_addr_o, m_pc);
        check_eq("imem_en", imem_en_o, !s && !r);
        @(posedge clk);
        if (r) begin
            m_pc = 32'h0; m_instr = 32'h0; m_ifid_pc = 32'h0; m_valid = 1'b0;
            m_pc_known = 1'b1; m_stalls = 0; m_flushes = 0;
        end else begin
            if (s) m_stalls++;
            if (b) m_flushes++;
            if (b) begin
                m_pc = t; m_instr = 32'h0; m_ifid_pc = 32'h0; m_valid = 1'b0; m_pc_known = 1'b1;
            end else if (s) begin
                // everything holds
            end else if (!rdy) begin
                m_instr = 32'h0; m_valid = 1'b0; m_pc_known = 1'b0;
            end else begin
                m_instr = mem_word(m_pc); m_ifid_pc = m_pc; m_valid = 1'b1;
                m_pc_known = 1'b1; m_pc = m_pc + 32'd4;
            end
        end
        #1;
        check_eq("ifid_instr", ifid_instr_o, m_instr);
        check_eq("ifid_valid", ifid_valid_o, m_valid);
        if (m_pc_known) check_eq("ifid_pc", ifid_pc_o, m_ifid_pc);
`ifdef FETCH_PERF_CNT_EN
        check_eq("perf_stall", perf_stall_o, m_stalls);
        check_eq("perf_flush", perf_flush_o, m_flushes);
`else
        check_eq("perf_stall", perf_stall_o, 32'h0);
        check_eq("perf_flush", perf_flush_o, 32'h0);
`endif
    endtask

    initial begin
        rst = 1'b1; stall_i = 1'b0; br_taken_i = 1'b0; br_target_i = 32'h0; imem_rdy_i = 1'b1;
        @(posedge clk);
        m_pc = 32'h0; m_instr = 32'h0; m_ifid_pc = 32'h0; m_valid = 1'b0;
        m_pc_known = 1'b1; m_stalls = 0; m_flushes = 0;

        // Reset, plain fetch to pc=8, 2-cycle stall, then fetch on to 0x10
        step(1, 0, 0, 32'h0, 1);
        step(0, 0, 0, 32'h0, 1);
        step(0, 0, 0, 32'h0, 1);
        step(0, 1, 0, 32'h0, 1);
        step(0, 1, 0, 32'h0, 1);
        step(0, 0, 0, 32'h0, 1);
        step(0, 0, 0, 32'h0, 1);
        // Redirect at pc=0x10 to 0x100, then redirect together with stall
        step(0, 0, 1, 32'h100, 1);
        step(0, 0, 0, 32'h0, 1);
        step(0, 1, 1, 32'h200, 1);
        step(0, 0, 0, 32'h0, 1);
        // Memory not ready for 3 cycles at 0x20
        step(0, 0, 1, 32'h20, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 32'h0, 0);
        step(0, 0, 0, 32'h0, 1);
        // PC wrap
        step(0, 0, 1, 32'hFFFF_FFFC, 1);
        step(0, 0, 0, 32'h0, 1);
        step(0, 0, 0, 32'h0, 1);
        check_eq("pc_wrap", imem_addr_o, 32'h4);
        // Reset in the middle of a stall and a wait
        step(0, 1, 0, 32'h0, 1);
        step(1, 1, 0, 32'h0, 0);
        step(0, 0, 0, 32'h0, 0);
        step(1, 0, 0, 32'h0, 0);
        step(0, 0, 0, 32'h0, 1);

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
            step($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 7) == 0, tgt, $urandom_range(0, 3) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
